// File: rtl/sdram_avalon_responder.sv
// Avalon-style SDRAM stand-in: rd_n/wr_n strobes, wait_req acknowledge, valid-pulse read return,
// backed by a small byte-lane RAM with periodic refresh stalls.
module sdram_avalon_responder #(
    parameter int MEM_AW         = 10,
    parameter int INIT_CYCLES    = 200,
    parameter int BUSY_CYCLES    = 2,
    parameter int READ_LATENCY   = 3,
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_rd_n,
    input  logic        i_wr_n,
    input  logic [21:0] i_addr,
    input  logic [15:0] i_data,
    input  logic [1:0]  i_be_n,
    output logic        o_wait_req,
    output logic        o_valid,
    output logic [15:0] o_data,
    output logic        o_init_done,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count
);

    localparam int CNT_W = 16;
    localparam int DP    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY,
        ST_REFRESH
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                rd_armed_reg;
    logic                wr_armed_reg;
    logic                pend_vld_reg;
    logic                pend_wr_reg;
    logic [MEM_AW-1:0]   pend_addr_reg;
    logic [15:0]         pend_data_reg;
    logic [1:0]          pend_be_n_reg;

    logic                cap_ok;
    logic                wr_hit;
    logic                rd_hit;
    logic                accept;
    logic                acc_wr;
    logic [MEM_AW-1:0]   acc_addr;
    logic [15:0]         acc_data;
    logic [1:0]          acc_be_n;
    logic                ram_we;
    logic                ram_re;
    logic [15:0]         ram_q;
    logic                refresh_due;
    logic                refresh_enter;

    logic [READ_LATENCY-1:0] vld_pipe_reg;
    logic [15:0]             data_pipe_reg [DP];
    logic [15:0]             rd_src;

    // Address bits above the RAM window are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[21:MEM_AW];

    // Strobes are only taken when re-armed, and only one command can wait in pending.
    assign cap_ok = ((state_reg == ST_IDLE) || (state_reg == ST_REFRESH)) && !pend_vld_reg;
    assign wr_hit = cap_ok && !i_wr_n && wr_armed_reg;
    assign rd_hit = cap_ok && !i_rd_n && rd_armed_reg;

    assign accept   = (state_reg == ST_IDLE) && (pend_vld_reg || wr_hit || rd_hit);
    assign acc_wr   = pend_vld_reg ? pend_wr_reg   : wr_hit;
    assign acc_addr = pend_vld_reg ? pend_addr_reg : i_addr[MEM_AW-1:0];
    assign acc_data = pend_vld_reg ? pend_data_reg : i_data;
    assign acc_be_n = pend_vld_reg ? pend_be_n_reg : i_be_n;
    assign ram_we   = accept && acc_wr;
    assign ram_re   = accept && !acc_wr;

    assign refresh_enter = (state_reg == ST_IDLE) && !accept && refresh_due;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            o_wait_req    <= 1'b1;
            o_init_done   <= 1'b0;
            o_rd_count    <= '0;
            o_wr_count    <= '0;
            rd_armed_reg  <= 1'b0;
            wr_armed_reg  <= 1'b0;
            pend_vld_reg  <= 1'b0;
            pend_wr_reg   <= 1'b0;
            pend_addr_reg <= '0;
            pend_data_reg <= '0;
            pend_be_n_reg <= '0;
        end else begin
            wr_armed_reg <= wr_hit ? 1'b0 : (i_wr_n ? 1'b1 : wr_armed_reg);
            rd_armed_reg <= rd_hit ? 1'b0 : (i_rd_n ? 1'b1 : rd_armed_reg);

            if (accept) begin
                pend_vld_reg <= 1'b0;
            end else if ((state_reg == ST_REFRESH) && (wr_hit || rd_hit)) begin
                pend_vld_reg  <= 1'b1;
                pend_wr_reg   <= wr_hit;
                pend_addr_reg <= i_addr[MEM_AW-1:0];
                pend_data_reg <= i_data;
                pend_be_n_reg <= i_be_n;
            end

            if (ram_we) begin
                o_wr_count <= o_wr_count + 1'b1;
            end
            if (ram_re) begin
                o_rd_count <= o_rd_count + 1'b1;
            end

            case (state_reg)
                ST_INIT: begin
                    if (cnt_reg == CNT_W'(INIT_CYCLES - 1)) begin
                        state_reg   <= ST_IDLE;
                        o_wait_req  <= 1'b0;
                        o_init_done <= 1'b1;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        state_reg  <= ST_BUSY;
                        o_wait_req <= 1'b1;
                        cnt_reg    <= '0;
                    end else if (refresh_enter) begin
                        state_reg  <= ST_REFRESH;
                        o_wait_req <= 1'b1;
                        cnt_reg    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg == CNT_W'(BUSY_CYCLES - 1)) begin
                        state_reg  <= ST_IDLE;
                        o_wait_req <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (cnt_reg == CNT_W'(REFRESH_CYCLES - 1)) begin
                        state_reg  <= ST_IDLE;
                        o_wait_req <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    generate
        if (REFRESH_PERIOD > 0) begin : g_refresh
            logic [CNT_W-1:0] tmr_reg;
            logic             due_reg;

            // A fresh request arriving on the entry edge wins over the clear, so none is lost.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tmr_reg <= '0;
                    due_reg <= 1'b0;
                end else if (state_reg != ST_INIT) begin
                    if (tmr_reg == CNT_W'(REFRESH_PERIOD - 1)) begin
                        tmr_reg <= '0;
                        due_reg <= 1'b1;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                        if (refresh_enter) begin
                            due_reg <= 1'b0;
                        end
                    end
                end
            end

            assign refresh_due = due_reg;
        end else begin : g_no_refresh
            assign refresh_due = 1'b0;
        end
    endgenerate

    // One byte-wide RAM per lane so each byte enable maps onto its own write port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [2**MEM_AW];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (ram_we && !acc_be_n[gi]) begin
                    mem[acc_addr] <= acc_data[gi*8 +: 8];
                end
                if (ram_re) begin
                    q_reg <= mem[acc_addr];
                end
            end

            assign ram_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_reg <= '0;
        end else begin
            vld_pipe_reg[0] <= ram_re;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_reg[i] <= vld_pipe_reg[i-1];
            end
        end
    end

    // ram_q holds between reads, so stage 0 can sample it every cycle.
    always_ff @(posedge clk) begin
        data_pipe_reg[0] <= ram_q;
        for (int i = 1; i < DP; i++) begin
            data_pipe_reg[i] <= data_pipe_reg[i-1];
        end
    end

    assign rd_src = (READ_LATENCY == 1) ? ram_q : data_pipe_reg[DP-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= vld_pipe_reg[READ_LATENCY-1];
            if (vld_pipe_reg[READ_LATENCY-1]) begin
                o_data <= rd_src;
            end
        end
    end

endmodule

// File: tb/tb_sdram_avalon_responder.sv
// Directed bench for sdram_avalon_responder: init, read/write handshakes, byte enables,
// aliasing, write-wins collision, refresh stall with pending read, and mid-read reset.
module tb_sdram_avalon_responder;

    logic        clk;
    logic        reset;
    logic        i_rd_n;
    logic        i_wr_n;
    logic [21:0] i_addr;
    logic [15:0] i_data;
    logic [1:0]  i_be_n;
    logic        o_wait_req;
    logic        o_valid;
    logic [15:0] o_data;
    logic        o_init_done;
    logic [31:0] o_rd_count;
    logic [31:0] o_wr_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    sdram_avalon_responder #(
        .MEM_AW         (10),
        .INIT_CYCLES    (200),
        .BUSY_CYCLES    (2),
        .READ_LATENCY   (3),
        .REFRESH_PERIOD (16),
        .REFRESH_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rd_n      (i_rd_n),
        .i_wr_n      (i_wr_n),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_be_n      (i_be_n),
        .o_wait_req  (o_wait_req),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_init_done (o_init_done),
        .o_rd_count  (o_rd_count),
        .o_wr_count  (o_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_wait_req && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vec_cnt++;
        if (o_wait_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s idle timeout: wait_req=%b want 0", tag, o_wait_req);
        end
    endtask

    task automatic check_counts(input string tag, input int exp_rd, input int exp_wr);
        vec_cnt++;
        if (o_rd_count !== 32'(exp_rd)) begin
            err_cnt++;
            $display("FAIL %s rd_count: got %0d want %0d", tag, o_rd_count, exp_rd);
        end
        vec_cnt++;
        if (o_wr_count !== 32'(exp_wr)) begin
            err_cnt++;
            $display("FAIL %s wr_count: got %0d want %0d", tag, o_wr_count, exp_wr);
        end
    endtask

    task automatic do_write(input logic [21:0] a, input logic [15:0] d,
                            input logic [1:0] be, input string tag);
        wait_idle(tag);
        i_wr_n = 1'b0;
        i_addr = a;
        i_data = d;
        i_be_n = be;
        @(negedge clk);
        i_wr_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vec_cnt++;
            if (o_wait_req !== (k < 2)) begin
                err_cnt++;
                $display("FAIL %s busy[%0d]: wait_req=%b want %b", tag, k, o_wait_req, (k < 2));
            end
            if (k < 2) @(negedge clk);
        end
        $display("write addr=%06h data=%04h be_n=%b", a, d, be);
    endtask

    task automatic do_read(input logic [21:0] a, input logic [15:0] exp, input string tag);
        wait_idle(tag);
        i_rd_n = 1'b0;
        i_addr = a;
        @(negedge clk);
        i_rd_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                vec_cnt++;
                if (o_wait_req !== (k < 2)) begin
                    err_cnt++;
                    $display("FAIL %s busy[%0d]: wait_req=%b want %b", tag, k, o_wait_req, (k < 2));
                end
            end
            vec_cnt++;
            if (o_valid !== (k == 3)) begin
                err_cnt++;
                $display("FAIL %s valid[%0d]: got %b want %b", tag, k, o_valid, (k == 3));
            end
            if (k >= 3) begin
                vec_cnt++;
                if (o_data !== exp) begin
                    err_cnt++;
                    $display("FAIL %s data[%0d]: got %04h want %04h", tag, k, o_data, exp);
                end
            end
            @(negedge clk);
        end
        $display("read  addr=%06h data=%04h expect=%04h", a, o_data, exp);
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        i_rd_n = 1'b1;
        i_wr_n = 1'b1;
        i_addr = '0;
        i_data = '0;
        i_be_n = 2'b00;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({o_wait_req, o_valid, o_init_done} !== 3'b100 || o_data !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset outputs: wait/valid/done=%b data=%04h want 100 0000",
                     {o_wait_req, o_valid, o_init_done}, o_data);
        end
        check_counts("reset", 0, 0);
        reset = 1'b0;
        begin
            int hi;
            hi = 0;
            while (o_wait_req && hi < 1000) begin
                hi++;
                @(negedge clk);
            end
            vec_cnt++;
            if (hi != 200) begin
                err_cnt++;
                $display("FAIL init length: wait_req high %0d cycles want 200", hi);
            end
        end
        vec_cnt++;
        if (o_init_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL init_done: got %b want 1", o_init_done);
        end
        check_counts("post_init", 0, 0);
        $display("reset released, init complete");
    endtask

    task automatic test_write_read;
        do_write(22'h000005, 16'hBEEF, 2'b00, "wr5");
        do_read(22'h000005, 16'hBEEF, "rd5");
        check_counts("wr_rd", 1, 1);
    endtask

    task automatic test_byte_enable;
        do_write(22'h000010, 16'h1234, 2'b00, "wr10a");
        do_write(22'h000010, 16'hABCD, 2'b10, "wr10b");
        do_read(22'h000010, 16'h12CD, "rd10");
        check_counts("byte_en", 2, 3);
    endtask

    task automatic test_alias;
        do_write(22'h000400, 16'h5555, 2'b00, "wr400");
        do_read(22'h000000, 16'h5555, "rd000");
        check_counts("alias", 3, 4);
    endtask

    task automatic test_both_low;
        wait_idle("both");
        i_rd_n = 1'b0;
        i_wr_n = 1'b0;
        i_addr = 22'h000020;
        i_data = 16'h7777;
        i_be_n = 2'b00;
        @(negedge clk);
        i_rd_n = 1'b1;
        i_wr_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vec_cnt++;
            if (o_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL both valid[%0d]: got %b want 0", k, o_valid);
            end
            @(negedge clk);
        end
        check_counts("both", 3, 5);
        $display("rd+wr addr=000020 data=7777 write taken");
        do_read(22'h000020, 16'h7777, "rd20");
        check_counts("both_rd", 4, 5);
    endtask

    task automatic test_refresh;
        int n;
        wait_idle("refresh");
        n = 0;
        while (!o_wait_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        vec_cnt++;
        if (o_wait_req !== 1'b1) begin
            err_cnt++;
            $display("FAIL refresh start: wait_req=%b want 1", o_wait_req);
        end
        i_rd_n = 1'b0;
        i_addr = 22'h000005;
        for (int i = 0; i < 14; i++) begin
            if (i <= 11) begin
                logic exp_w;
                exp_w = (i < 8) || (i == 9) || (i == 10);
                vec_cnt++;
                if (o_wait_req !== exp_w) begin
                    err_cnt++;
                    $display("FAIL refresh wait[%0d]: got %b want %b", i, o_wait_req, exp_w);
                end
            end
            vec_cnt++;
            if (o_valid !== (i == 12)) begin
                err_cnt++;
                $display("FAIL refresh valid[%0d]: got %b want %b", i, o_valid, (i == 12));
            end
            if (i == 12) begin
                vec_cnt++;
                if (o_data !== 16'hBEEF) begin
                    err_cnt++;
                    $display("FAIL refresh data: got %04h want BEEF", o_data);
                end
            end
            @(negedge clk);
            i_rd_n = 1'b1;
        end
        check_counts("refresh", 5, 5);
        $display("read  addr=000005 during refresh data=%04h", o_data);
    endtask

    task automatic test_reset_mid_read;
        wait_idle("midrst");
        i_rd_n = 1'b0;
        i_addr = 22'h000005;
        @(negedge clk);
        i_rd_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vec_cnt++;
            if ({o_valid, o_wait_req, o_init_done} !== 3'b010) begin
                err_cnt++;
                $display("FAIL midrst[%0d] valid/wait/done: got %b want 010",
                         k, {o_valid, o_wait_req, o_init_done});
            end
            @(negedge clk);
        end
        check_counts("midrst", 0, 0);
        $display("reset during read, no return");
        do_read(22'h000005, 16'hBEEF, "rd5_after_rst");
        check_counts("midrst_rd", 1, 0);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_enable;
        test_alias;
        test_both_low;
        test_refresh;
        test_reset_mid_read;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sdram_avalon_responder.md
Name: sdram_avalon_responder

Overview:
- Behavioural and synthesizable Avalon-style slave that stands in for the SDRAM controller at the far end of the test initiator's rd_n/wr_n/wait_req/valid interface.
- Responds with the same handshake the initiator expects:
  - wait_req held high during init;
  - wait_req rising acknowledges a command;
  - a one-cycle valid pulse returns read data.
- Backs commands with a small on-chip RAM and injects periodic refresh stalls so the initiator's busy handling gets exercised on-board and in simulation.

Parameters:
- MEM_AW, 10, RAM address width; 2**MEM_AW 16-bit words, indexed by i_addr[MEM_AW-1:0].
- INIT_CYCLES, 200, cycles of wait_req high after reset release (>=1).
- BUSY_CYCLES, 2, cycles wait_req stays high after accepting a command (>=1).
- READ_LATENCY, 3, cycles from read acceptance edge to valid pulse (>=1).
- REFRESH_PERIOD, 780, cycles between refresh requests; 0 disables refresh.
- REFRESH_CYCLES, 8, wait_req-high cycles per refresh (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_rd_n  in  1  read strobe, active low.
- i_wr_n  in  1  write strobe, active low.
- i_addr  in  22  word address; bits above MEM_AW-1 ignored, so addresses alias.
- i_data  in  16  write data.
- i_be_n  in  2  byte enables, active low; [1]=upper byte, [0]=lower byte.
- o_wait_req  out  1  busy/acknowledge.
- o_valid  out  1  one-cycle read-data-valid pulse.
- o_data  out  16  read data; holds last returned value.
- o_init_done  out  1  high once INIT completes.
- o_rd_count  out  32  accepted reads, wraps.
- o_wr_count  out  32  accepted writes, wraps.

Behaviour:
- Reset (async):
  - state=INIT, o_wait_req=1, o_valid=0, o_data=0, o_init_done=0, counters 0.
  - Read pipeline flushed; refresh timer cleared; pending/armed flags cleared.
  - RAM contents are not cleared.
- States: INIT, IDLE, BUSY, REFRESH. o_wait_req=0 only in IDLE.
- INIT:
  - Counts INIT_CYCLES cycles, then goes to IDLE and sets o_init_done=1 (sticky until reset).
  - Strobes are ignored in INIT.
- Command capture:
  - A strobe is captured when sampled low in IDLE or REFRESH, and only if that strobe was sampled high at least once since the previous acceptance (re-arm).
  - Strobes are ignored in BUSY.
  - rd_n and wr_n low in the same cycle: write wins, the read is dropped and not counted.
  - Capture holds addr, data and be_n in a one-deep pending register.
- IDLE:
  - A pending or newly captured command is accepted: go to BUSY.
  - Otherwise, if refresh_due, go to REFRESH.
  - A command always has priority over refresh.
- Accept (the edge entering BUSY):
  - Write: RAM updated per byte enable on that edge; o_wr_count+1.
  - Read: RAM read issued, tag enters pipeline; o_rd_count+1.
  - Pending is cleared.
- BUSY: o_wait_req=1 for BUSY_CYCLES cycles, then IDLE.
- REFRESH:
  - o_wait_req=1 for REFRESH_CYCLES cycles, then IDLE; refresh_due is cleared on entry.
  - A strobe captured during REFRESH stays pending and is accepted on the IDLE cycle that follows.
- Refresh timer:
  - Runs in every state except INIT.
  - refresh_due is set when the timer reaches REFRESH_PERIOD-1; the timer then restarts.
  - A due flag not yet serviced does not stack (max one outstanding).
- Read return:
  - o_valid=1 for exactly one cycle, READ_LATENCY cycles after the accept edge.
  - o_data updates on that same edge and holds until the next valid.
  - Reads return RAM contents as of accept time, so a later write does not affect an in-flight read.
  - Pipeline depth is READ_LATENCY; at most one read is in flight given BUSY_CYCLES>=1 re-arm, but the pipeline must tolerate one per accept.
- Reset asserted mid-operation: in-flight read discarded, no valid pulse; sequence restarts at INIT.

Test Plan:
- Reset release, no strobes -> o_wait_req=1 for 200 cycles, then 0 with o_init_done=1; counters 0.
- Write addr 0x005=0xBEEF, then read 0x005 -> wait_req high 2 cycles after each accept; o_valid pulse 3 cycles after read accept, o_data=0xBEEF held afterward; o_wr_count=1, o_rd_count=1.
- Write 0x010=0x1234, then write 0x010=0xABCD with i_be_n=2'b10 -> read 0x010 returns 0x12CD.
- Alias: write 0x000400=0x5555 (MEM_AW=10), read 0x000000 -> 0x5555.
- rd_n and wr_n low together at addr 0x020 with data 0x7777 -> write performed, no valid pulse, o_wr_count+1, o_rd_count unchanged.
- REFRESH_PERIOD=16: rd_n falls on the cycle REFRESH begins -> wait_req stays high 8 cycles, read is accepted right after with wait_req high 2 more cycles, valid follows 3 cycles after accept, exactly one valid. Separately, reset pulse 1 cycle after a read accept -> no o_valid, state INIT.
